// File: rtl/lsu_input_port_pkg.sv
// Shared definitions for the LSU input peripheral: register offsets, load types
// and the load-data formatting helper used by the read path.
package lsu_io_pkg;

    localparam logic [5:0] OFF_SW       = 6'h00;
    localparam logic [5:0] OFF_BTN      = 6'h10;
    localparam logic [5:0] OFF_FLAG     = 6'h20;
    localparam logic [5:0] OFF_EDGE     = 6'h30;
    localparam logic [5:0] OFF_IRQ_MASK = 6'h34;

    typedef enum logic [2:0] {
        F3_LB  = 3'd0,
        F3_LH  = 3'd1,
        F3_LW  = 3'd2,
        F3_LBU = 3'd4,
        F3_LHU = 3'd5
    } funct3_e;

    // Misaligned halves/words still return the aligned-down lanes.
    function automatic logic [31:0] load_format(input logic [31:0] data,
                                                input logic [1:0]  off,
                                                input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{off, 3'b000} +: 8];
        h = off[1] ? data[31:16] : data[15:0];
        case (funct3_e'(funct3))
            F3_LB:   return {{24{b[7]}}, b};
            F3_LBU:  return {24'h0, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LHU:  return {16'h0, h};
            F3_LW:   return data;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] off,
                                           input logic [2:0] funct3);
        case (funct3_e'(funct3))
            F3_LH, F3_LHU: return off[0];
            F3_LW:         return off != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_input_port_if.sv
// LSU-side bus of the input peripheral: address/strobes/store data in,
// formatted load data and decode status out.
interface lsu_input_port_if;
    logic [31:0] i_lsu_addr;
    logic        i_lsu_rden;
    logic        i_lsu_wren;
    logic [31:0] i_lsu_wdata;
    logic [2:0]  i_funct3;
    logic [31:0] o_rdata;
    logic        o_hit;
    logic        o_misalign;

    modport master (
        output i_lsu_addr, i_lsu_rden, i_lsu_wren, i_lsu_wdata, i_funct3,
        input  o_rdata, o_hit, o_misalign
    );

    modport slave (
        input  i_lsu_addr, i_lsu_rden, i_lsu_wren, i_lsu_wdata, i_funct3,
        output o_rdata, o_hit, o_misalign
    );
endinterface

// File: rtl/lsu_input_port_debounce.sv
// One button: SYNC_STAGES-deep synchroniser followed by a stability counter that
// only accepts a new level after DEBOUNCE_CYC consecutive differing cycles.
module io_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_stable
);
    localparam int              CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   stable_reg;
    logic                   sync_bit;

    assign sync_bit = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_reg   <= '0;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_raw};
            if (sync_bit == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // Terminal count: accept the new level; the counter never wraps.
                stable_reg <= sync_bit;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign o_stable = stable_reg;
endmodule

// File: rtl/lsu_input_port.sv
// Memory-mapped switch/button input port for the LSU read mux (MA stage).
// Optional feature: define INPUT_IRQ_EN to add IRQ_MASK and a registered o_irq.
module lsu_input_port
    import lsu_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_7800,
    parameter int          SW_W         = 32,
    parameter int          BTN_W        = 4,
    parameter int          SYNC_STAGES  = 2,
    parameter int          DEBOUNCE_CYC = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [SW_W-1:0]  i_io_sw,
    input  logic [BTN_W-1:0] i_io_btn,
    input  logic             i_ack,
    lsu_input_port_if.slave  bus,
    output logic             o_irq
);
    logic [5:0]       off;
    logic             in_window;
    logic             hit;
    logic             is_load;
    logic             is_store;
    logic [SW_W-1:0]  sw_sync_reg [SYNC_STAGES];
    logic [BTN_W-1:0] btn_stable;
    logic [BTN_W-1:0] btn_stable_d_reg;
    logic [BTN_W-1:0] btn_rise;
    logic [BTN_W-1:0] edge_reg;
    logic [BTN_W-1:0] edge_next;
    logic [BTN_W-1:0] edge_clr;
    logic             flag_reg;
    logic             flag_next;
    logic [31:0]      reg_word;
    logic             unused_wdata_bits;

    assign off       = {bus.i_lsu_addr[5:2], 2'b00};
    assign in_window = (bus.i_lsu_addr[31:6] == BASE_ADDR[31:6]);
    // Gating with reset keeps every output at 0 while reset is held.
    assign hit       = i_rst_n && in_window && (bus.i_lsu_rden || bus.i_lsu_wren);
    assign is_load   = hit && bus.i_lsu_rden && !bus.i_lsu_wren;
    assign is_store  = hit && bus.i_lsu_wren;

    assign unused_wdata_bits = ^bus.i_lsu_wdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sw_sync_reg[s] <= '0;
        end else begin
            sw_sync_reg[0] <= i_io_sw;
            for (int s = 1; s < SYNC_STAGES; s++) sw_sync_reg[s] <= sw_sync_reg[s-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BTN_W; gi++) begin : g_btn
            io_debounce #(
                .SYNC_STAGES  (SYNC_STAGES),
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_debounce (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_raw    (i_io_btn[gi]),
                .o_stable (btn_stable[gi])
            );
        end
    endgenerate

    assign btn_rise = btn_stable & ~btn_stable_d_reg;

    always_comb begin
        edge_clr = '0;
        if (is_store && off == OFF_EDGE) edge_clr = bus.i_lsu_wdata[BTN_W-1:0];
        // A new rising edge survives a simultaneous W1C of the same bit.
        edge_next = (edge_reg & ~edge_clr) | btn_rise;
        flag_next = flag_reg;
        if (i_ack) begin
            flag_next = 1'b1;
        end else if ((is_load || is_store) && off == OFF_FLAG) begin
            flag_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_stable_d_reg <= '0;
            edge_reg         <= '0;
            flag_reg         <= 1'b0;
        end else begin
            btn_stable_d_reg <= btn_stable;
            edge_reg         <= edge_next;
            flag_reg         <= flag_next;
        end
    end

`ifdef INPUT_IRQ_EN
    logic [BTN_W-1:0] mask_reg;
    logic             irq_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mask_reg <= '0;
            irq_reg  <= 1'b0;
        end else begin
            if (is_store && off == OFF_IRQ_MASK) mask_reg <= bus.i_lsu_wdata[BTN_W-1:0];
            irq_reg <= |(edge_reg & mask_reg);
        end
    end

    assign o_irq = irq_reg;
`else
    assign o_irq = 1'b0;
`endif

    always_comb begin
        reg_word = '0;
        case (off)
            OFF_SW:       reg_word[SW_W-1:0]  = sw_sync_reg[SYNC_STAGES-1];
            OFF_BTN:      reg_word[BTN_W-1:0] = btn_stable;
            OFF_FLAG:     reg_word[0]         = flag_reg | i_ack;
            OFF_EDGE:     reg_word[BTN_W-1:0] = edge_reg;
`ifdef INPUT_IRQ_EN
            OFF_IRQ_MASK: reg_word[BTN_W-1:0] = mask_reg;
`endif
            default:      reg_word = '0;
        endcase
    end

    assign bus.o_hit      = hit;
    assign bus.o_misalign = hit && is_misaligned(bus.i_lsu_addr[1:0], bus.i_funct3);
    assign bus.o_rdata    = is_load ? load_format(reg_word, bus.i_lsu_addr[1:0], bus.i_funct3)
                                    : 32'h0;
endmodule
